// File: rtl/booth_op_sequencer.sv
// booth_op_sequencer: buffers operand pairs, issues them to a fixed-latency Booth multiplier
// and presents each captured product on a valid/ready output stream.
module booth_op_sequencer #(
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int MUL_LAT = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        mul_start,
  output logic [31:0] mul_in1,
  output logic [31:0] mul_in2,
  input  logic [63:0] mul_result,
  output logic        busy
);
  localparam int CW = $clog2(MUL_LAT);
  localparam logic [CW-1:0] LAST = CW'(MUL_LAT - 1);
  typedef enum logic [1:0] {IDLE, START, WAIT} state_e;
  state_e state_q, state_d;
  logic [63:0] fifo_q [DEPTH];
  logic [63:0] fifo_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic out_valid_q, out_valid_d, mul_start_q, mul_start_d;
  logic [63:0] out_result_q, out_result_d;
  logic [31:0] mul_in1_q, mul_in1_d, mul_in2_q, mul_in2_d;
  logic push, pop, empty, capture;
  assign empty      = count_q == '0;
  assign in_ready   = count_q != (AW+1)'(DEPTH);
  assign push       = in_valid & in_ready;
  assign pop        = (state_q == IDLE) & ~empty;
  // A finished result may wait in WAIT until the single output slot frees up.
  assign capture    = (state_q == WAIT) & (cnt_q == LAST) & (~out_valid_q | out_ready);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign mul_start  = mul_start_q;
  assign mul_in1    = mul_in1_q;
  assign mul_in2    = mul_in2_q;
  assign busy       = (state_q != IDLE) | ~empty | out_valid_q;
  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = {in_a, in_b};
    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
    state_d      = state_q == IDLE  ? (pop ? START : IDLE) :
                   state_q == START ? WAIT : (capture ? IDLE : WAIT);
    cnt_d        = state_q == START ? '0 :
                   (state_q == WAIT && cnt_q != LAST) ? cnt_q + 1'b1 : cnt_q;
    mul_start_d  = pop;
    mul_in1_d    = pop ? fifo_q[rd_ptr_q][63:32] : mul_in1_q;
    mul_in2_d    = pop ? fifo_q[rd_ptr_q][31:0] : mul_in2_q;
    out_valid_d  = capture | (out_valid_q & ~out_ready);
    out_result_d = capture ? mul_result : out_result_q;
  end
  always_ff @(posedge clk) fifo_q <= fifo_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cnt_q        <= '0;
      mul_start_q  <= 1'b0;
      mul_in1_q    <= '0;
      mul_in2_q    <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cnt_q        <= cnt_d;
      mul_start_q  <= mul_start_d;
      mul_in1_q    <= mul_in1_d;
      mul_in2_q    <= mul_in2_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
    end
  end
endmodule

// File: tb/tb_booth_op_sequencer.sv
// tb_booth_op_sequencer: directed and scoreboarded checks of the Booth operand sequencer
module tb_booth_op_sequencer;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [31:0] in_a = 0, in_b = 0;
  logic in_ready, out_valid, mul_start, busy;
  logic [63:0] out_result;
  logic [63:0] mul_result = 64'h0;
  logic [31:0] mul_in1, mul_in2;
  int checks = 0, failures = 0, start_cycles = 0, out_cnt = 0;
  int mk = 0, n, bad, base;
  bit mact = 0, full_seen = 0, done6;
  logic [63:0] exp_q [$];
  always #5 clk = ~clk;
  booth_op_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .mul_start(mul_start), .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_result(mul_result),
    .busy(busy)
  );
  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y;
    x = {{32{a[31]}}, a};
    y = {{32{b[31]}}, b};
    return x * y;
  endfunction
  // Multiplier stand-in: garbage after load, true product written 17 edges later from live inputs.
  always @(posedge clk) begin
    if (mul_start) begin
      mact <= 1;
      mk <= 0;
      mul_result <= 64'hBADC0FFEE0DDF00D;
    end else if (mact) begin
      mk <= mk + 1;
      if (mk == 16) begin
        mul_result <= smul(mul_in1, mul_in2);
        mact <= 0;
      end
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) exp_q.delete();
      else begin
        if (mul_start) start_cycles++;
        if (in_valid && !in_ready) full_seen = 1;
        if (in_valid && in_ready) exp_q.push_back(smul(in_a, in_b));
        if (out_valid && out_ready) begin
          out_cnt++;
          if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
          else check("sb_product", out_result, exp_q.pop_front());
        end
      end
    end
  endtask
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bit ok = 0;
    in_a = a;
    in_b = b;
    in_valid = 1;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    if (!ok) check("send_timeout", 0, 1);
  endtask
  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!out_valid && cyc < 200);
  endtask
  task automatic drain();
    bit ok = 0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(posedge clk);
      @(negedge clk);
      ok = exp_q.size() == 0 && !busy;
    end
    check("drain", ok, 1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_in1", mul_in1, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    start_cycles = 0;
    send(3, 5);
    wait_out(n);
    check("t1_latency", n, 20);
    check("t1_result", out_result, 64'h000000000000000F);
    @(posedge clk);
    @(negedge clk);
    check("t1_busy_after", busy, 0);
    check("t1_start_pulse", start_cycles, 1);
    @(posedge clk);
    #1;
    send(32'hFFFFFFF9, 6);
    n = 0;
    bad = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (mul_in1 !== 32'hFFFFFFF9 || mul_in2 !== 32'd6) bad++;
    end while (!out_valid && n < 200);
    check("t2_latency", n, 20);
    check("t2_result", out_result, 64'hFFFFFFFFFFFFFFD6);
    check("t2_operand_hold", bad, 0);
    @(posedge clk);
    #1;
    full_seen = 0;
    base = out_cnt;
    send(32'd11, 32'd13);
    for (int i = 0; i < 6; i++) send(32'd100 + i, 32'hFFFFFFF0 - i);
    check("t3_full_seen", full_seen, 1);
    drain();
    check("t3_out_count", out_cnt - base, 7);
    out_ready = 0;
    send(32'd100, 32'hFFFFFFFE);
    send(32'h7FFFFFFF, 32'h7FFFFFFF);
    bad = 0;
    repeat (60) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid && out_result !== 64'hFFFFFFFFFFFFFF38) bad++;
    end
    check("t4_held_valid", out_valid, 1);
    check("t4_held_result", out_result, 64'hFFFFFFFFFFFFFF38);
    check("t4_hold_stable", bad, 0);
    check("t4_busy", busy, 1);
    @(posedge clk);
    #1 out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    check("t4_second_valid", out_valid, 1);
    check("t4_second_result", out_result, 64'h3FFFFFFF00000001);
    @(posedge clk);
    @(negedge clk);
    check("t4_drained", out_valid, 0);
    @(posedge clk);
    #1;
    send(32'd1000, 32'd1000);
    send(32'd7, 32'd9);
    send(32'd2, 32'd4);
    repeat (8) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("t5_out_valid", out_valid, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_busy", busy, 0);
    check("t5_mul_start", mul_start, 0);
    check("t5_mul_in2", mul_in2, 0);
    @(posedge clk);
    #1;
    send(32'd12, 32'hFFFFFFFD);
    wait_out(n);
    check("t5_latency", n, 20);
    check("t5_result", out_result, 64'hFFFFFFFFFFFFFFDC);
    drain();
    done6 = 0;
    base = out_cnt;
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send($urandom(), $urandom());
        end
        done6 = 1;
      end
      while (!done6) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    out_ready = 1;
    drain();
    check("t6_out_count", out_cnt - base, 50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/booth_op_sequencer.md
Name: booth_op_sequencer

Overview:
Operand-side sequencer for the radix-4 Booth multiplier. It accepts 32-bit operand pairs on a valid/ready stream and buffers them in a small FIFO. It issues each pair to the multiplier with a one-cycle start pulse, holds the operands stable, and counts the multiplier's fixed latency. It then captures the 64-bit product and presents it on a valid/ready output stream.

Parameters:
DEPTH, 4, operand FIFO entries (power of 2, >=2)
AW, 2, FIFO pointer width, log2(DEPTH)
MUL_LAT, 18, clock edges from the multiplier load edge to the capture edge (16 Booth steps + 1 result-write edge + 1 margin)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept (= !full)
in_a  in  32  multiplicand, two's complement
in_b  in  32  multiplier, two's complement
out_valid  out  1  product valid
out_ready  in  1  downstream accepts product
out_result  out  64  signed product
mul_start  out  1  start pulse to multiplier
mul_in1  out  32  multiplier in1, held for the whole operation
mul_in2  out  32  multiplier in2, held for the whole operation
mul_result  in  64  multiplier result
busy  out  1  (state!=IDLE) | !empty | out_valid

Behaviour:
- Reset (sync, at the clk edge with rst=1): state=IDLE, FIFO pointers and count = 0, out_valid=0, out_result=0, mul_start=0, mul_in1=mul_in2=0, cnt=0. in_ready=1 in the cycle after reset.
- FIFO: push on in_valid&in_ready. Pop only in IDLE when non-empty at the edge. No fall-through: an entry pushed at edge P is popped no earlier than edge P+1. Push and pop in the same edge are allowed, and count is unchanged. in_ready=0 when count==DEPTH. Pointers wrap modulo DEPTH.
- IDLE: if !empty, pop head into mul_in1/mul_in2, set mul_start<=1, go to START. Otherwise stay.
- START: mul_start is high for exactly this one cycle. The multiplier loads at the next edge (load edge L). At L: mul_start<=0, cnt<=0, go to WAIT.
- WAIT: cnt increments each edge and saturates at MUL_LAT-1. Capture happens when cnt==MUL_LAT-1 and the output slot is free (out_valid==0 | out_ready). On capture: out_result<=mul_result, out_valid<=1, go to IDLE. If the slot is not free, stay in WAIT with mul_in1/mul_in2 unchanged. The multiplier result stays stable, so a late capture is safe.
- mul_in1/mul_in2 change only on a pop.
- Output: out_valid clears on out_valid&out_ready. A capture in the same edge keeps out_valid=1 and loads the new result. out_result is stable while out_valid&!out_ready.
- Latency, empty idle block with out_ready=1: push at edge P, pop at P+1, load at P+2, out_valid high after edge P+20. Back-to-back issue interval is 20 cycles.
- Ordering: products leave in the same order as operand pairs were accepted.
- Reset mid-operation: all state is cleared and the queued and in-flight operations are discarded. The multiplier has no reset, so its abandoned computation is ignored. The next start pulse reinitialises it.
- The arithmetic result is whatever the multiplier produces. This block never modifies data. Expected value is the signed product modulo 2^64.

Test Plan:
1. Reset, then push a=3, b=5 with out_ready=1 -> mul_start high for exactly 1 cycle; out_valid rises 20 edges after the push with out_result=64'h000000000000000F; busy=0 afterward.
2. Push a=-7 (32'hFFFFFFF9), b=6 -> out_result=64'hFFFFFFFFFFFFFFD6. mul_in1/mul_in2 stay constant from the pop until capture.
3. Hold in_valid=1 for 6 cycles with distinct pairs while the first operation runs -> in_ready drops after the FIFO holds 4 entries. All accepted pairs produce correct products in order. The pair offered during in_ready=0 is not lost and is accepted later.
4. out_ready=0 for 60 cycles with two ops queued -> the first result is held stable; the second op stalls in WAIT with cnt saturated. On out_ready=1, the results come out one per handshake in order, and out_valid never deasserts between them if the capture coincides.
5. Assert rst for 1 cycle during WAIT with 2 entries queued -> next cycle: out_valid=0, in_ready=1, busy=0, mul_start=0. A new push of 12*-3 yields 64'hFFFFFFFFFFFFFFDC.
6. Simultaneous push and pop at count=1 -> count stays 1, and no entry is duplicated or dropped (checked by a scoreboard over 50 random pairs against a reference signed product).
